alu_op_sequencer: RTL and testbench

Parametrised control sequencer that turns one ALU command into the timed datapath strobe sequence: register-out, Y load, ALU to Z, and Z writeback. The strobe sequence matches the one driven by hand for single ops such as negate. It generalises that to binary, unary and wide (HI/LO) modes, any register count, and multi-cycle ALU latency. A valid/ready handshake accepts the command. The block sits between the future instruction decoder and data_path.

---
 rtl/alu_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Control sequencer turning one ALU command into the timed datapath strobe
// sequence: register-out, Y load, ALU to Z, Z writeback (LO/HI for wide ops).
module alu_op_sequencer #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned REG_IDX_W   = 4,
  parameter int unsigned OP_W        = 5,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                 Clock,
  input  logic                 clear,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [1:0]           cmd_mode,
  input  logic [REG_IDX_W-1:0] cmd_ra,
  input  logic [REG_IDX_W-1:0] cmd_rb,
  input  logic [REG_IDX_W-1:0] cmd_rc,
  output logic [OP_W-1:0]      op,
  output logic [NUM_REGS-1:0]  reg_out,
  output logic [NUM_REGS-1:0]  reg_in,
  output logic                 Yin,
  output logic                 Zlowin,
  output logic                 Zhighin,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 LOin,
  output logic                 HIin,
  output logic                 done,
  output logic                 cmd_err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LATENCY - 1);
  localparam logic LAT_ONE = (ALU_LATENCY == 1);

  localparam logic [1:0] MODE_UNARY = 2'b01;
  localparam logic [1:0] MODE_WIDE  = 2'b10;
  localparam logic [1:0] MODE_ILL   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_Y_LOAD,
    S_ALU,
    S_ZLO_WB,
    S_ZHI_WB
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [REG_IDX_W-1:0]   src_l;
  logic [REG_IDX_W-1:0]   rc_l;
  logic                   wide_l;
  logic                   cmd_reject;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  function automatic logic idx_bad(input logic [REG_IDX_W-1:0] idx);
    return 32'(idx) >= NUM_REGS;
  endfunction

  // Ready only while idle and out of reset; state is registered so no cmd_* path.
  assign cmd_ready = (state == S_IDLE) && clear;

  // Illegal mode or any index that the mode actually uses is out of range.
  always_comb begin
    cmd_reject = 1'b0;
    if (cmd_mode == MODE_ILL) cmd_reject = 1'b1;
    if (idx_bad(cmd_ra)) cmd_reject = 1'b1;
    if ((cmd_mode != MODE_UNARY) && idx_bad(cmd_rb)) cmd_reject = 1'b1;
    if ((cmd_mode != MODE_WIDE) && idx_bad(cmd_rc)) cmd_reject = 1'b1;
  end

  // Sequencer FSM; every strobe is registered and computed for the state being entered.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      cnt      <= '0;
      src_l    <= '0;
      rc_l     <= '0;
      wide_l   <= 1'b0;
      op       <= '0;
      reg_out  <= '0;
      reg_in   <= '0;
      Yin      <= 1'b0;
      Zlowin   <= 1'b0;
      Zhighin  <= 1'b0;
      Zlowout  <= 1'b0;
      Zhighout <= 1'b0;
      LOin     <= 1'b0;
      HIin     <= 1'b0;
      done     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      reg_out  <= '0;
      reg_in   <= '0;
      Yin      <= 1'b0;
      Zlowin   <= 1'b0;
      Zhighin  <= 1'b0;
      Zlowout  <= 1'b0;
      Zhighout <= 1'b0;
      LOin     <= 1'b0;
      HIin     <= 1'b0;
      done     <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_reject) begin
              cmd_err <= 1'b1;
            end else begin
              op      <= cmd_op;
              rc_l    <= cmd_rc;
              wide_l  <= (cmd_mode == MODE_WIDE);
              src_l   <= (cmd_mode == MODE_UNARY) ? cmd_ra : cmd_rb;
              reg_out <= onehot(cmd_ra);
              if (cmd_mode == MODE_UNARY) begin
                // Unary skips the Y load; ra feeds the ALU directly.
                state  <= S_ALU;
                cnt    <= LAT_M1;
                Zlowin <= LAT_ONE;
              end else begin
                state <= S_Y_LOAD;
                Yin   <= 1'b1;
              end
            end
          end
        end
        S_Y_LOAD: begin
          state   <= S_ALU;
          cnt     <= LAT_M1;
          reg_out <= onehot(src_l);
          Zlowin  <= LAT_ONE;
          Zhighin <= LAT_ONE && wide_l;
        end
        S_ALU: begin
          if (cnt == '0) begin
            state   <= S_ZLO_WB;
            Zlowout <= 1'b1;
            if (wide_l) begin
              LOin <= 1'b1;
            end else begin
              reg_in <= onehot(rc_l);
              done   <= 1'b1;
            end
          end else begin
            cnt     <= cnt - CNT_W'(1);
            reg_out <= onehot(src_l);
            if (cnt == CNT_W'(1)) begin
              Zlowin  <= 1'b1;
              Zhighin <= wide_l;
            end
          end
        end
        S_ZLO_WB: begin
          if (wide_l) begin
            state    <= S_ZHI_WB;
            Zhighout <= 1'b1;
            HIin     <= 1'b1;
            done     <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ZHI_WB: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: two sequencer instances (16 regs/latency 1, 12 regs/latency 3)
// share one randomized command stream; a reference model predicts per-cycle strobes.
module tb_alu_op_sequencer;

  logic       Clock;
  logic       clear;
  logic       cmd_valid;
  logic [4:0] cmd_op;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_ra, cmd_rb, cmd_rc;

  logic        a_cmd_ready, a_Yin, a_Zlowin, a_Zhighin, a_Zlowout, a_Zhighout;
  logic        a_LOin, a_HIin, a_done, a_cmd_err;
  logic [4:0]  a_op;
  logic [15:0] a_reg_out, a_reg_in;

  logic        b_cmd_ready, b_Yin, b_Zlowin, b_Zhighin, b_Zlowout, b_Zhighout;
  logic        b_LOin, b_HIin, b_done, b_cmd_err;
  logic [4:0]  b_op;
  logic [11:0] b_reg_out, b_reg_in;

  alu_op_sequencer #(.NUM_REGS(16), .REG_IDX_W(4), .OP_W(5), .ALU_LATENCY(1)) dut_a (
    .Clock(Clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc),
    .op(a_op), .reg_out(a_reg_out), .reg_in(a_reg_in), .Yin(a_Yin),
    .Zlowin(a_Zlowin), .Zhighin(a_Zhighin), .Zlowout(a_Zlowout), .Zhighout(a_Zhighout),
    .LOin(a_LOin), .HIin(a_HIin), .done(a_done), .cmd_err(a_cmd_err)
  );

  alu_op_sequencer #(.NUM_REGS(12), .REG_IDX_W(4), .OP_W(5), .ALU_LATENCY(3)) dut_b (
    .Clock(Clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc),
    .op(b_op), .reg_out(b_reg_out), .reg_in(b_reg_in), .Yin(b_Yin),
    .Zlowin(b_Zlowin), .Zhighin(b_Zhighin), .Zlowout(b_Zlowout), .Zhighout(b_Zhighout),
    .LOin(b_LOin), .HIin(b_HIin), .done(b_done), .cmd_err(b_cmd_err)
  );

  typedef struct packed {
    logic [15:0] ro;
    logic [15:0] ri;
    logic        yin, zlin, zhin, zlout, zhout, loin, hiin, done, err;
  } strb_t;

  typedef struct {
    int    cyc;
    strb_t s;
  } rec_t;

  rec_t       qa[$];
  rec_t       qb[$];
  int         busy_until [2];
  logic [4:0] last_op [2];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Cycle index; outputs seen at the negedge of cycle c follow the edge that ended c-1.
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic push(input int i, input int c, input strb_t s);
    rec_t r;
    r.cyc = c;
    r.s   = s;
    if (i == 0) qa.push_back(r);
    else        qb.push_back(r);
  endtask

  // Reference: the whole strobe timeline of one command accepted at the edge ending cycle c.
  task automatic gen(input int i, input int c, input logic [4:0] opc, input logic [1:0] mode,
                     input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    int    lat, nregs, k;
    logic  bad;
    logic [3:0] src;
    strb_t s;
    lat   = (i == 0) ? 1 : 3;
    nregs = (i == 0) ? 16 : 12;
    bad = (mode == 2'd3) || (int'(ra) >= nregs) ||
          (mode != 2'd1 && int'(rb) >= nregs) || (mode != 2'd2 && int'(rc) >= nregs);
    if (bad) begin
      s = '0; s.err = 1'b1;
      push(i, c + 1, s);
      busy_until[i] = c + 1;
      return;
    end
    last_op[i] = opc;
    k = 1;
    if (mode != 2'd1) begin
      s = '0; s.ro = 16'(1) << ra; s.yin = 1'b1;
      push(i, c + k, s);
      k++;
    end
    src = (mode == 2'd1) ? ra : rb;
    for (int j = 0; j < lat; j++) begin
      s = '0; s.ro = 16'(1) << src;
      s.zlin = (j == lat - 1);
      s.zhin = (j == lat - 1) && (mode == 2'd2);
      push(i, c + k, s);
      k++;
    end
    if (mode == 2'd2) begin
      s = '0; s.zlout = 1'b1; s.loin = 1'b1;
      push(i, c + k, s);
      k++;
      s = '0; s.zhout = 1'b1; s.hiin = 1'b1; s.done = 1'b1;
      push(i, c + k, s);
    end else begin
      s = '0; s.zlout = 1'b1; s.ri = 16'(1) << rc; s.done = 1'b1;
      push(i, c + k, s);
    end
    busy_until[i] = c + k + 1;
  endtask

  // Model: reset flushes every pending expectation; otherwise accept when idle.
  always @(posedge Clock or negedge clear) begin
    if (!clear) begin
      qa.delete();
      qb.delete();
      for (int i = 0; i < 2; i++) begin
        busy_until[i] = 0;
        last_op[i]    = '0;
      end
    end else if (cmd_valid) begin
      for (int i = 0; i < 2; i++)
        if (cyc >= busy_until[i]) gen(i, cyc, cmd_op, cmd_mode, cmd_ra, cmd_rb, cmd_rc);
    end
  end

  function automatic strb_t pack_a();
    strb_t s;
    s.ro = a_reg_out; s.ri = a_reg_in; s.yin = a_Yin; s.zlin = a_Zlowin; s.zhin = a_Zhighin;
    s.zlout = a_Zlowout; s.zhout = a_Zhighout; s.loin = a_LOin; s.hiin = a_HIin;
    s.done = a_done; s.err = a_cmd_err;
    return s;
  endfunction

  function automatic strb_t pack_b();
    strb_t s;
    s.ro = 16'(b_reg_out); s.ri = 16'(b_reg_in); s.yin = b_Yin; s.zlin = b_Zlowin;
    s.zhin = b_Zhighin; s.zlout = b_Zlowout; s.zhout = b_Zhighout; s.loin = b_LOin;
    s.hiin = b_HIin; s.done = b_done; s.err = b_cmd_err;
    return s;
  endfunction

  task automatic check_inst(input int i, input strb_t act, input logic rdy, input logic [4:0] opv);
    logic  exp_rdy;
    logic  have;
    rec_t  r;
    strb_t exp;
    exp_rdy = clear && (cyc >= busy_until[i]);
    checks++;
    if (rdy !== exp_rdy) begin
      errors++;
      $display("FAIL ready_%0d cyc=%0d actual=%b expected=%b", i, cyc, rdy, exp_rdy);
    end
    checks++;
    if (opv !== last_op[i]) begin
      errors++;
      $display("FAIL op_%0d cyc=%0d actual=%h expected=%h", i, cyc, opv, last_op[i]);
    end
    have = 1'b0;
    if (i == 0) begin
      if (qa.size() > 0 && qa[0].cyc <= cyc) begin r = qa.pop_front(); have = 1'b1; end
    end else begin
      if (qb.size() > 0 && qb[0].cyc <= cyc) begin r = qb.pop_front(); have = 1'b1; end
    end
    exp = '0;
    if (have && r.cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_%0d cyc=%0d actual=absent expected=record@%0d", i, cyc, r.cyc);
    end else if (have) begin
      exp = r.s;
    end
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL strobes_%0d cyc=%0d actual=%h expected=%h", i, cyc, act, exp);
    end
  endtask

  // Monitor: compares both instances every cycle, away from the active edge.
  always @(negedge Clock) begin
    check_inst(0, pack_a(), a_cmd_ready, a_op);
    check_inst(1, pack_b(), b_cmd_ready, b_op);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic issue(input logic [4:0] o, input logic [1:0] m,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    @(negedge Clock);
    cmd_valid = 1'b1; cmd_op = o; cmd_mode = m; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc;
    @(negedge Clock);
    cmd_valid = 1'b0;
  endtask

  initial begin
    clear = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_mode = '0;
    cmd_ra = '0; cmd_rb = '0; cmd_rc = '0;
    idle(3);
    clear = 1'b1;
    idle(2);
    issue(5'b01000, 2'b01, 4'd7, 4'd0, 4'd6);   // negate R7 -> R6
    idle(8);
    issue(5'b00011, 2'b00, 4'd2, 4'd3, 4'd1);   // binary R2,R3 -> R1
    idle(8);
    issue(5'b00101, 2'b10, 4'd4, 4'd5, 4'd14);  // wide R4,R5; rc ignored
    idle(10);
    issue(5'b00111, 2'b11, 4'd1, 4'd2, 4'd3);   // illegal mode
    idle(3);
    issue(5'b01001, 2'b00, 4'd13, 4'd1, 4'd2);  // ra=13: legal for 16 regs, rejected for 12
    idle(8);
    issue(5'b01010, 2'b00, 4'd3, 4'd4, 4'd5);   // reset lands in the ALU state
    @(posedge Clock);
    #2 clear = 1'b0;
    idle(2);
    #1 clear = 1'b1;
    idle(1);
    issue(5'b01011, 2'b00, 4'd8, 4'd9, 4'd10);
    idle(8);
    // held valid: second unary command waits at the source
    @(negedge Clock);
    cmd_valid = 1'b1; cmd_op = 5'b10001; cmd_mode = 2'b01; cmd_ra = 4'd1; cmd_rc = 4'd2;
    @(negedge Clock);
    cmd_op = 5'b10010; cmd_ra = 4'd3; cmd_rc = 4'd3;
    idle(12);
    cmd_valid = 1'b0;
    idle(8);
    for (int n = 0; n < 500; n++) begin
      @(negedge Clock);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 5'($urandom_range(0, 31));
      cmd_mode  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cmd_ra    = 4'($urandom_range(0, 15));
      cmd_rb    = 4'($urandom_range(0, 15));
      cmd_rc    = 4'($urandom_range(0, 15));
    end
    @(negedge Clock);
    cmd_valid = 1'b0;
    idle(25);
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL drain_0 actual=%0d pending expected=0", qa.size());
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL drain_1 actual=%0d pending expected=0", qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
